// File: rtl/zssd_window_engine.sv
// Streaming ZSSD/SSD window engine: accumulates f, g and (f-g)^2 over N = 2^LOG2_N pixel
// pairs, then produces N*Sd2 - (Sf-Sg)^2 (mode 0) or N*Sd2 (mode 1) behind valid/ready.
module zssd_window_engine #(
    parameter int PIX_W  = 8,
    parameter int LOG2_N = 8,
    parameter bit NORM   = 1'b0,
    localparam int RES_W = 2*PIX_W + 2*LOG2_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] f_pix,
    input  logic [PIX_W-1:0] g_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] zssd,
    output logic             busy
);
    localparam int SW = PIX_W + LOG2_N;
    localparam int QW = 2*PIX_W + LOG2_N;

    typedef enum logic [2:0] {IDLE, ACCUM, CALC, FIN, DONE} state_t;

    state_t              state_reg, state_next;
    logic                mode_reg;
    logic [SW-1:0]       sf_reg, sg_reg;
    logic [QW-1:0]       sd2_reg;
    logic [LOG2_N-1:0]   cnt_reg;
    logic [RES_W-1:0]    p_reg, d2_reg, zssd_reg;

    logic                accept, last_pair;
    logic [PIX_W-1:0]    pix_diff;
    logic [2*PIX_W-1:0]  pix_sq;
    logic [SW-1:0]       sum_diff;
    logic [RES_W-1:0]    sum_sq, r_val, zssd_fin;

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign zssd      = zssd_reg;

    assign accept    = in_valid & in_ready;
    assign last_pair = (cnt_reg == {LOG2_N{1'b1}});

    // Squaring the magnitude gives the same result as squaring the signed difference.
    assign pix_diff = (f_pix >= g_pix) ? (f_pix - g_pix) : (g_pix - f_pix);
    assign pix_sq   = pix_diff * pix_diff;
    assign sum_diff = (sf_reg >= sg_reg) ? (sf_reg - sg_reg) : (sg_reg - sf_reg);
    assign sum_sq   = sum_diff * sum_diff;

    // P >= D2 always holds (Cauchy-Schwarz), so the subtraction cannot wrap.
    assign r_val = mode_reg ? p_reg : (p_reg - d2_reg);

    generate
        if (NORM) begin : g_norm
            assign zssd_fin = r_val >> LOG2_N;
        end else begin : g_raw
            assign zssd_fin = r_val;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (accept && last_pair) state_next = CALC;
            CALC:    state_next = FIN;
            FIN:     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            mode_reg  <= 1'b0;
            sf_reg    <= '0;
            sg_reg    <= '0;
            sd2_reg   <= '0;
            cnt_reg   <= '0;
            p_reg     <= '0;
            d2_reg    <= '0;
            zssd_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg <= mode;
                        sf_reg   <= '0;
                        sg_reg   <= '0;
                        sd2_reg  <= '0;
                        cnt_reg  <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        sf_reg  <= sf_reg + SW'(f_pix);
                        sg_reg  <= sg_reg + SW'(g_pix);
                        sd2_reg <= sd2_reg + QW'(pix_sq);
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CALC: begin
                    p_reg  <= {sd2_reg, {LOG2_N{1'b0}}};
                    d2_reg <= sum_sq;
                end
                FIN:     zssd_reg <= zssd_fin;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_zssd_window_engine.sv
// Randomised bench for zssd_window_engine: a raw and a normalised instance share stimulus
// and are compared against a sum-based reference model of each window.
module tb_zssd_window_engine;
    localparam int PIX_W  = 8;
    localparam int LOG2_N = 8;
    localparam int N      = 1 << LOG2_N;
    localparam int RES_W  = 2*PIX_W + 2*LOG2_N;
    localparam int HOLD   = 20;

    logic             clk = 1'b0;
    logic             rst, start, mode, in_valid, out_ready;
    logic [PIX_W-1:0] f_pix, g_pix;
    logic             in_ready0, out_valid0, busy0;
    logic             in_ready1, out_valid1, busy1;
    logic [RES_W-1:0] zssd0, zssd1;

    int n_checks = 0;
    int n_fail   = 0;
    int f_arr[N];
    int g_arr[N];

    always #5 clk = ~clk;

    zssd_window_engine #(.PIX_W(PIX_W), .LOG2_N(LOG2_N), .NORM(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready0), .f_pix(f_pix), .g_pix(g_pix),
        .out_valid(out_valid0), .out_ready(out_ready), .zssd(zssd0), .busy(busy0)
    );

    zssd_window_engine #(.PIX_W(PIX_W), .LOG2_N(LOG2_N), .NORM(1'b1)) dut_norm (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready1), .f_pix(f_pix), .g_pix(g_pix),
        .out_valid(out_valid1), .out_ready(out_ready), .zssd(zssd1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window contents for the next run.
    task automatic fill(input int pat);
        int k;
        k = $urandom_range(0, 255);
        for (int i = 0; i < N; i++) begin
            case (pat)
                0: begin f_arr[i] = k; g_arr[i] = k; end
                1: begin g_arr[i] = $urandom_range(0, 245); f_arr[i] = g_arr[i] + 10; end
                2: begin f_arr[i] = 255; g_arr[i] = 0; end
                3: begin f_arr[i] = (i % 2 == 1) ? 255 : 0; g_arr[i] = 0; end
                5: begin g_arr[i] = $urandom_range(0, 252); f_arr[i] = g_arr[i] + 3; end
                default: begin f_arr[i] = $urandom_range(0, 255); g_arr[i] = $urandom_range(0, 255); end
            endcase
        end
    endtask

    function automatic longint model(input int m, input int norm);
        longint sf, sg, sd2, r;
        sf = 0; sg = 0; sd2 = 0;
        for (int i = 0; i < N; i++) begin
            sf  += f_arr[i];
            sg  += g_arr[i];
            sd2 += longint'(f_arr[i] - g_arr[i]) * longint'(f_arr[i] - g_arr[i]);
        end
        r = longint'(N) * sd2;
        if (m == 0) r -= (sf - sg) * (sf - sg);
        if (norm != 0) r = r / N;
        return r;
    endfunction

    task automatic run_window(input int m, input bit gaps, input bit hold,
                              input longint exp_raw, input longint exp_norm,
                              output logic [RES_W-1:0] res);
        longint e0, e1;
        int i, cyc;
        logic [RES_W-1:0] z;
        e0 = model(m, 0);
        e1 = model(m, 1);
        @(negedge clk);
        start = 1'b1; mode = m[0]; in_valid = 1'b0;
        i = 0; cyc = 0;
        while (i < N && cyc < 4*N + 50) begin
            @(negedge clk);
            cyc++;
            start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            mode  = 1'($urandom_range(0, 1));
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                f_pix = 8'($urandom); g_pix = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                f_pix = 8'(f_arr[i]); g_pix = 8'(g_arr[i]);
            end
            if (in_valid && in_ready0) i++;
        end
        check("accepted", 64'(i), 64'(N));
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; f_pix = 8'hff; g_pix = 8'h00;
        check("rdy_after_last", 64'(in_ready0), 64'd0);
        cyc = 0;
        while (!out_valid0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("out_valid", 64'(out_valid0), 64'd1);
        check("zssd", 64'(zssd0), 64'(e0));
        check("zssd_norm", 64'(zssd1), 64'(e1));
        if (exp_raw >= 0)  check("zssd_const", 64'(zssd0), 64'(exp_raw));
        if (exp_norm >= 0) check("zssd_norm_const", 64'(zssd1), 64'(exp_norm));
        res = zssd0;
        if (hold) begin
            z = zssd0;
            repeat (HOLD) begin
                @(negedge clk);
                start = 1'($urandom_range(0, 1));
                check("hold_valid", 64'(out_valid0), 64'd1);
                check("hold_zssd", 64'(zssd0), 64'(z));
                check("hold_ready", 64'(in_ready0), 64'd0);
            end
        end
        @(negedge clk);
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        check("idle_valid", 64'(out_valid0), 64'd0);
        check("idle_busy", 64'(busy0), 64'd0);
        $display("window mode=%0d gaps=%0d hold=%0d zssd=%0d zssd_norm=%0d", m, gaps, hold, zssd0, zssd1);
    endtask

    initial begin
        logic [RES_W-1:0] r1, r2;
        int acc;
        rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        f_pix = '0; g_pix = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready0), 64'd0);
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_zssd", 64'(zssd0), 64'd0);
        rst = 1'b0;

        fill(0);
        run_window(0, 1'b0, 1'b0, 0, 0, r1);
        run_window(1, 1'b0, 1'b0, 0, 0, r1);
        fill(1);
        run_window(0, 1'b0, 1'b0, 0, 0, r1);
        run_window(1, 1'b0, 1'b0, 64'd6553600, 64'd25600, r1);
        fill(2);
        run_window(1, 1'b0, 1'b0, 64'd4261478400, 64'd16646400, r1);
        run_window(0, 1'b0, 1'b0, 0, 0, r1);
        fill(3);
        run_window(0, 1'b0, 1'b0, 64'd1065369600, 64'd4161600, r1);

        fill(4);
        run_window(0, 1'b0, 1'b0, -1, -1, r1);
        run_window(0, 1'b1, 1'b1, -1, -1, r2);
        check("gap_equal", 64'(r2), 64'(r1));

        // Abort a window part-way through, then make sure nothing leaks into the next one.
        fill(4);
        @(negedge clk);
        start = 1'b1; mode = 1'b1;
        acc = 0;
        for (int c = 0; c < 4*N && acc < 100; c++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1;
            f_pix = 8'(f_arr[acc]); g_pix = 8'(g_arr[acc]);
            if (in_ready0) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy0), 64'd0);
        check("abort_ready", 64'(in_ready0), 64'd0);
        check("abort_zssd", 64'(zssd0), 64'd0);
        fill(5);
        run_window(1, 1'b0, 1'b0, 64'd589824, 64'd2304, r1);

        repeat (4) begin
            fill($urandom_range(0, 5));
            run_window($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'b0, -1, -1, r1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
